cdb_arbiter: RTL and testbench

// - Common-data-bus scheduler for the out-of-order core. Captures the one-cycle result pulses from the
//   add/sub (and later) functional units into per-unit holding slots.
// - Each cycle it grants at most one slot to the single CDB, round-robin.
// - The CDB is the broadcast seen by the reorder buffer and the reservation stations.
// - Replaces "every unit broadcasts at once". Also tells each reservation station when its unit may not issue.

---
 rtl/cdb_arbiter_pkg.sv | 33 +++
 rtl/cdb_arbiter_if.sv | 37 +++
 rtl/cdb_arbiter_rr_pick.sv | 33 +++
 rtl/cdb_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus (CDB) scheduler.
// The reorder buffer and the reservation stations import this package and
// consume one cdb_t broadcast instead of scanning per-unit result arrays.
//   NUM_FU   : number of functional units; unit index 1..NUM_FU is the CDB tag
//   DATA_W   : result width
//   TAG_W    : tag width (matches rstation alu1/alu2 and rbuffer.alu fields)
//   TAG_NONE : tag value meaning "no producer"
package cdb_arbiter_pkg;

    localparam int unsigned NUM_FU = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 8;

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
        logic              bfail;
    } cdb_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Round-robin successor of unit g, wrapping n -> 1.
    function automatic int unsigned rr_next(input int unsigned g, input int unsigned n);
        return (g == n) ? 1 : g + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle between the functional units / reservation stations and the CDB
// scheduler.
//   fu_valid/fu_value/fu_bfail [1:N] : one-cycle result pulses from each unit
//   flush                            : mispredict squash of all pending results
//   fu_full [1:N]                    : back-pressure, slot i occupied
//   cdb_valid/cdb_tag/cdb_value/cdb_bfail : registered broadcast
//   overflow [1:N]                   : sticky dropped-result flags
// master = unit/pipeline side, slave = scheduler side.
interface cdb_arbiter_if #(
    parameter int unsigned NUM_FU = cdb_arbiter_pkg::NUM_FU,
    parameter int unsigned DATA_W = cdb_arbiter_pkg::DATA_W,
    parameter int unsigned TAG_W  = cdb_arbiter_pkg::TAG_W
);

    logic [NUM_FU:1]   fu_valid;
    logic [DATA_W-1:0] fu_value [1:NUM_FU];
    logic [NUM_FU:1]   fu_bfail;
    logic              flush;

    logic [NUM_FU:1]   fu_full;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;
    logic              cdb_bfail;
    logic [NUM_FU:1]   overflow;

    modport master (
        output fu_valid, fu_value, fu_bfail, flush,
        input  fu_full, cdb_valid, cdb_tag, cdb_value, cdb_bfail, overflow
    );

    modport slave (
        input  fu_valid, fu_value, fu_bfail, flush,
        output fu_full, cdb_valid, cdb_tag, cdb_value, cdb_bfail, overflow
    );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// cdb_rr_pick: combinational rotate-priority encoder.
// Searches full[] starting at rr_ptr, ascending and wrapping NUM_FU -> 1, and
// returns the first set index.
//   full[1:N]    : in  slot occupancy
//   rr_ptr       : in  first index to examine (1..NUM_FU)
//   grant_valid  : out some slot was selected
//   grant_idx    : out selected index (1..NUM_FU), 0 when !grant_valid
module cdb_rr_pick #(
    parameter int unsigned NUM_FU = 8,
    parameter int unsigned IDX_W  = 4
) (
    input  logic [NUM_FU:1]  full,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            // rr_ptr is 1-based; rotate in 0-based space then shift back.
            idx = ((32'(rr_ptr) + k - 1) % NUM_FU) + 1;
            if (!grant_valid && full[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus scheduler.
// Captures one-cycle result pulses from the functional units into per-unit
// holding slots, grants at most one FULL slot per cycle round-robin, and
// drives the registered CDB broadcast seen by the reorder buffer and the
// reservation stations.
//   clk       : clock
//   RSTN_N    : asynchronous active-low reset
//   bus       : cdb_arbiter_if slave (unit pulses, flush, fu_full, CDB, overflow)
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU = cdb_arbiter_pkg::NUM_FU,
    parameter int unsigned DATA_W = cdb_arbiter_pkg::DATA_W,
    parameter int unsigned TAG_W  = cdb_arbiter_pkg::TAG_W
) (
    input  logic         clk,
    input  logic         RSTN_N,
    cdb_arbiter_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_FU + 1);

    slot_state_e       state      [1:NUM_FU];
    slot_state_e       state_next [1:NUM_FU];
    logic [DATA_W-1:0] slot_value [1:NUM_FU];
    logic [NUM_FU:1]   slot_bfail;
    logic [NUM_FU:1]   full;
    logic [NUM_FU:1]   load;
    logic [NUM_FU:1]   granted;
    logic [NUM_FU:1]   ovf_set;
    logic [NUM_FU:1]   ovf_q;

    logic [IDX_W-1:0]  rr_ptr;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic              grant;
    logic [DATA_W-1:0] sel_value;
    logic              sel_bfail;

    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_value_q;
    logic              cdb_bfail_q;

    always_comb begin
        full = '0;
        for (int unsigned i = 1; i <= NUM_FU; i++) begin
            full[i] = (state[i] == SLOT_FULL);
        end
    end

    cdb_rr_pick #(
        .NUM_FU (NUM_FU),
        .IDX_W  (IDX_W)
    ) u_pick (
        .full        (full),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // Flush suppresses the grant so the pointer holds and nothing is broadcast.
    assign grant = grant_valid && !bus.flush;

    // Per-slot next state; a slot granted this edge may reload from its unit.
    always_comb begin
        granted = '0;
        load    = '0;
        ovf_set = '0;
        for (int unsigned i = 1; i <= NUM_FU; i++) begin
            state_next[i] = state[i];
            granted[i]    = grant && (grant_idx == IDX_W'(i));
            if (bus.flush) begin
                state_next[i] = SLOT_EMPTY;
            end else begin
                unique case (state[i])
                    SLOT_EMPTY: begin
                        if (bus.fu_valid[i]) begin
                            load[i]       = 1'b1;
                            state_next[i] = SLOT_FULL;
                        end
                    end
                    SLOT_FULL: begin
                        if (granted[i]) begin
                            if (bus.fu_valid[i]) begin
                                load[i] = 1'b1;
                            end else begin
                                state_next[i] = SLOT_EMPTY;
                            end
                        end else if (bus.fu_valid[i]) begin
                            ovf_set[i] = 1'b1;
                        end
                    end
                    default: state_next[i] = SLOT_EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge RSTN_N) begin
        if (!RSTN_N) begin
            for (int unsigned i = 1; i <= NUM_FU; i++) begin
                state[i] <= SLOT_EMPTY;
            end
        end else begin
            for (int unsigned i = 1; i <= NUM_FU; i++) begin
                state[i] <= state_next[i];
            end
        end
    end

    always_ff @(posedge clk or negedge RSTN_N) begin
        if (!RSTN_N) begin
            for (int unsigned i = 1; i <= NUM_FU; i++) begin
                slot_value[i] <= '0;
            end
            slot_bfail <= '0;
        end else begin
            for (int unsigned i = 1; i <= NUM_FU; i++) begin
                if (load[i]) begin
                    slot_value[i] <= bus.fu_value[i];
                    slot_bfail[i] <= bus.fu_bfail[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge RSTN_N) begin
        if (!RSTN_N) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_q | ovf_set;
        end
    end

    always_ff @(posedge clk or negedge RSTN_N) begin
        if (!RSTN_N) begin
            rr_ptr <= IDX_W'(1);
        end else if (grant) begin
            rr_ptr <= IDX_W'(rr_next(32'(grant_idx), NUM_FU));
        end
    end

    // One-hot mux of the granted slot's contents.
    always_comb begin
        sel_value = '0;
        sel_bfail = 1'b0;
        for (int unsigned i = 1; i <= NUM_FU; i++) begin
            if (granted[i]) begin
                sel_value = slot_value[i];
                sel_bfail = slot_bfail[i];
            end
        end
    end

    always_ff @(posedge clk or negedge RSTN_N) begin
        if (!RSTN_N) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= TAG_NONE;
            cdb_value_q <= '0;
            cdb_bfail_q <= 1'b0;
        end else if (grant) begin
            cdb_valid_q <= 1'b1;
            cdb_tag_q   <= TAG_W'(grant_idx);
            cdb_value_q <= sel_value;
            cdb_bfail_q <= sel_bfail;
        end else begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= TAG_NONE;
            cdb_value_q <= '0;
            cdb_bfail_q <= 1'b0;
        end
    end

    assign bus.fu_full   = full;
    assign bus.overflow  = ovf_q;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_value = cdb_value_q;
    assign bus.cdb_bfail = cdb_bfail_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by random
// pulses/flushes, all compared every cycle against a slot/queue-level model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = NUM_FU;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk    (clk),
        .RSTN_N (rstn),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: which units hold an unbroadcast result, and the
    // next unit in line for the round-robin turn.
    bit          m_full [1:N];
    logic [31:0] m_val  [1:N];
    bit          m_bf   [1:N];
    bit          m_ovf  [1:N];
    int          m_ptr;
    bit          m_cv;
    int          m_ct;
    logic [31:0] m_cval;
    bit          m_cbf;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = ((m_ptr - 1 + k) % N) + 1;
            if (m_full[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 1; i <= N; i++) begin
            m_full[i] = 0; m_val[i] = '0; m_bf[i] = 0; m_ovf[i] = 0;
        end
        m_ptr = 1; m_cv = 0; m_ct = 0; m_cval = '0; m_cbf = 0;
    endtask

    task automatic model_edge();
        int g;
        if (!rstn) begin
            model_reset();
            return;
        end
        if (bus.flush) begin
            for (int i = 1; i <= N; i++) m_full[i] = 0;
            m_cv = 0; m_ct = 0; m_cval = '0; m_cbf = 0;
            return;
        end
        g = pick();
        if (g != 0) begin
            m_cv = 1; m_ct = g; m_cval = m_val[g]; m_cbf = m_bf[g];
            m_ptr = (g == N) ? 1 : g + 1;
        end else begin
            m_cv = 0; m_ct = 0; m_cval = '0; m_cbf = 0;
        end
        for (int i = 1; i <= N; i++) begin
            if (bus.fu_valid[i]) begin
                if (!m_full[i] || i == g) begin
                    m_full[i] = 1; m_val[i] = bus.fu_value[i]; m_bf[i] = bus.fu_bfail[i];
                end else begin
                    m_ovf[i] = 1;
                end
            end else if (i == g) begin
                m_full[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        logic [N:1] ef, eo;
        for (int i = 1; i <= N; i++) begin
            ef[i] = m_full[i];
            eo[i] = m_ovf[i];
        end
        chk("fu_full",   64'(bus.fu_full),   64'(ef));
        chk("overflow",  64'(bus.overflow),  64'(eo));
        chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_cv));
        chk("cdb_tag",   64'(bus.cdb_tag),   64'(m_ct));
        chk("cdb_value", 64'(bus.cdb_value), 64'(m_cval));
        chk("cdb_bfail", 64'(bus.cdb_bfail), 64'(m_cbf));
    endtask

    task automatic clear_in();
        bus.fu_valid = '0;
        bus.fu_bfail = '0;
        bus.flush    = 1'b0;
        for (int i = 1; i <= N; i++) bus.fu_value[i] = '0;
    endtask

    task automatic pulse(input int i, input logic [31:0] v, input bit bf);
        bus.fu_valid[i] = 1'b1;
        bus.fu_value[i] = v;
        bus.fu_bfail[i] = bf;
    endtask

    // Advance one clock: model follows the edge, outputs checked at negedge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset from mid-cycle; outputs must clear with no clock edge.
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        int tags [0:5];
        clear_in();
        model_reset();
        #2;
        compare_all();
        chk("reset_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        #10;
        rstn = 1'b1;
        @(negedge clk);

        // 1: single pulse, two-edge latency, one cycle of back-pressure
        pulse(3, 32'd42, 1'b0);
        cycle();
        chk("t1_full3_set",  64'(bus.fu_full[3]), 64'd1);
        chk("t1_cdb_idle",   64'(bus.cdb_valid),  64'd0);
        clear_in();
        cycle();
        chk("t1_tag",        64'(bus.cdb_tag),    64'd3);
        chk("t1_value",      64'(bus.cdb_value),  64'd42);
        chk("t1_full3_clr",  64'(bus.fu_full[3]), 64'd0);
        cycle();

        // 2: three simultaneous pulses drain in order 1,2,3
        do_reset();
        pulse(1, 32'd10, 1'b0); pulse(2, 32'd20, 1'b1); pulse(3, 32'd30, 1'b0);
        cycle();
        clear_in();
        for (int k = 1; k <= 3; k++) begin
            cycle();
            chk("t2_tag",   64'(bus.cdb_tag),   64'(k));
            chk("t2_value", 64'(bus.cdb_value), 64'(10 * k));
        end
        cycle();

        // 3: unit 1 refills whenever its slot frees; unit 4 must still win a turn
        do_reset();
        pulse(1, 32'h100, 1'b0); pulse(4, 32'h400, 1'b1);
        cycle();
        for (int k = 0; k < 6; k++) begin
            clear_in();
            if (!m_full[1] || pick() == 1) pulse(1, 32'h100 + k + 1, 1'b0);
            cycle();
            tags[k] = int'(bus.cdb_tag);
        end
        chk("t3_order0", 64'(tags[0]), 64'd1);
        chk("t3_order1", 64'(tags[1]), 64'd4);
        chk("t3_order2", 64'(tags[2]), 64'd1);
        chk("t3_order3", 64'(tags[3]), 64'd1);
        chk("t3_no_ovf", 64'(bus.overflow), 64'd0);
        clear_in();
        cycle(); cycle();

        // 4: repeat pulse into an ungranted full slot is dropped and flagged
        do_reset();
        pulse(1, 32'd5, 1'b0); pulse(2, 32'd6, 1'b0);
        cycle();
        clear_in();
        pulse(2, 32'd7, 1'b0);
        cycle();
        clear_in();
        chk("t4_ovf2", 64'(bus.overflow[2]), 64'd1);
        chk("t4_ovf1", 64'(bus.overflow[1]), 64'd0);
        cycle();
        chk("t4_tag",   64'(bus.cdb_tag),   64'd2);
        chk("t4_value", 64'(bus.cdb_value), 64'd6);
        cycle(); cycle();
        chk("t4_ovf2_sticky", 64'(bus.overflow[2]), 64'd1);

        // 5: flush discards pending slots and a same-edge pulse
        pulse(2, 32'h22, 1'b0); pulse(5, 32'h55, 1'b1);
        cycle();
        clear_in();
        bus.flush = 1'b1;
        pulse(6, 32'h66, 1'b0);
        cycle();
        clear_in();
        chk("t5_no_cdb", 64'(bus.cdb_valid), 64'd0);
        chk("t5_empty",  64'(bus.fu_full),   64'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t5_no_tag6", 64'(bus.cdb_tag == 8'd6), 64'd0);
        end

        // 6: async reset while busy, then first result is from unit 7
        pulse(1, 32'h11, 1'b0); pulse(2, 32'h12, 1'b0);
        pulse(3, 32'h13, 1'b0); pulse(4, 32'h14, 1'b0);
        cycle();
        clear_in();
        pulse(1, 32'h15, 1'b1);
        cycle();
        clear_in();
        chk("t6_busy", 64'(bus.cdb_valid), 64'd1);
        #2;
        do_reset();
        chk("t6_rst_cdb",  64'(bus.cdb_valid), 64'd0);
        chk("t6_rst_full", 64'(bus.fu_full),   64'd0);
        @(negedge clk);
        pulse(7, 32'h77, 1'b0);
        cycle();
        clear_in();
        cycle();
        chk("t6_tag7", 64'(bus.cdb_tag), 64'd7);
        cycle();

        // Random traffic, including overflows and flushes
        do_reset();
        @(negedge clk);
        for (int c = 0; c < 400; c++) begin
            clear_in();
            for (int i = 1; i <= N; i++) begin
                if ($urandom_range(0, 99) < 30) pulse(i, $urandom, 1'($urandom_range(0, 1)));
            end
            bus.flush = ($urandom_range(0, 99) < 4);
            cycle();
        end
        clear_in();
        for (int c = 0; c < N + 2; c++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
